// File: rtl/bscan_pkg.sv
// Shared TAP state encodings, instruction opcodes and the TAP next-state rule
// for the boundary-scan controller.
package bscan_pkg;

  localparam int unsigned TAP_W = 4;
  localparam int unsigned IR_W  = 2;

  typedef enum logic [TAP_W-1:0] {
    TAP_EXIT2_DR = 4'h0,
    TAP_EXIT1_DR = 4'h1,
    TAP_SHIFT_DR = 4'h2,
    TAP_PAUSE_DR = 4'h3,
    TAP_SEL_IR   = 4'h4,
    TAP_UPD_DR   = 4'h5,
    TAP_CAP_DR   = 4'h6,
    TAP_SEL_DR   = 4'h7,
    TAP_EXIT2_IR = 4'h8,
    TAP_EXIT1_IR = 4'h9,
    TAP_SHIFT_IR = 4'hA,
    TAP_PAUSE_IR = 4'hB,
    TAP_RTI      = 4'hC,
    TAP_UPD_IR   = 4'hD,
    TAP_CAP_IR   = 4'hE,
    TAP_TLR      = 4'hF
  } tap_state_e;

  typedef enum logic [IR_W-1:0] {
    IR_EXTEST = 2'b00,
    IR_SAMPLE = 2'b01,
    IR_INTEST = 2'b10,
    IR_BYPASS = 2'b11
  } ir_op_e;

  // Fixed pattern loaded into the IR shift stage on Capture-IR.
  localparam logic [IR_W-1:0] IR_CAPTURE = 2'b01;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      TAP_TLR:      tap_next = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      tap_next = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   tap_next = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   tap_next = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: tap_next = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: tap_next = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: tap_next = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: tap_next = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   tap_next = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   tap_next = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   tap_next = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: tap_next = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: tap_next = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: tap_next = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: tap_next = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   tap_next = tms ? TAP_SEL_DR   : TAP_RTI;
      default:      tap_next = TAP_TLR;
    endcase
  endfunction

endpackage

// File: rtl/bscan_tap_fsm.sv
// 16-state TAP controller with one-hot decodes of the states the data
// and instruction paths act on.
module bscan_tap_fsm
  import bscan_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tms_i,
  output tap_state_e state_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       capture_ir_o,
  output logic       shift_ir_o,
  output logic       update_ir_o,
  output logic       sel_ir_o,
  output logic       tlr_o
);

  tap_state_e state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= TAP_TLR;
    else       state_q <= tap_next(state_q, tms_i);
  end

  assign state_o      = state_q;
  assign capture_dr_o = (state_q == TAP_CAP_DR);
  assign shift_dr_o   = (state_q == TAP_SHIFT_DR);
  assign update_dr_o  = (state_q == TAP_UPD_DR);
  assign capture_ir_o = (state_q == TAP_CAP_IR);
  assign shift_ir_o   = (state_q == TAP_SHIFT_IR);
  assign update_ir_o  = (state_q == TAP_UPD_IR);
  assign sel_ir_o     = (state_q == TAP_SEL_IR);
  assign tlr_o        = (state_q == TAP_TLR);

endmodule

// File: rtl/bscan_boundary_tap.sv
// Boundary-scan wrapper: TAP controller, IR, bypass bit, boundary shift/update
// register and the pin/core muxes around the core under test.
module bscan_boundary_tap
  import bscan_pkg::*;
#(
  parameter int unsigned NIn  = 3,
  parameter int unsigned NOut = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              TMS,
  input  logic              TDI,
  output logic              TDO,
  output logic              TDO_En,
  input  logic [NIn-1:0]    PinIn,
  output logic [NIn-1:0]    CoreIn,
  input  logic [NOut-1:0]   CoreOut,
  output logic [NOut-1:0]   PinOut,
  output logic [TAP_W-1:0]  TapState
);

  localparam int unsigned BrW = NIn + NOut;

  tap_state_e          tap_state;
  logic                capture_dr, shift_dr, update_dr;
  logic                capture_ir, shift_ir, update_ir;
  logic                sel_ir, tlr;

  ir_op_e              ir_q, ir_d;
  logic [IR_W-1:0]     irs_q, irs_d;
  logic [BrW-1:0]      br_q, br_d;
  logic [BrW-1:0]      ur_q, ur_d;
  logic                bypass_q, bypass_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;
  logic                br_sel;

  bscan_tap_fsm u_fsm (
    .clk_i        (Clk),
    .rst_i        (Reset),
    .tms_i        (TMS),
    .state_o      (tap_state),
    .capture_dr_o (capture_dr),
    .shift_dr_o   (shift_dr),
    .update_dr_o  (update_dr),
    .capture_ir_o (capture_ir),
    .shift_ir_o   (shift_ir),
    .update_ir_o  (update_ir),
    .sel_ir_o     (sel_ir),
    .tlr_o        (tlr)
  );

  assign br_sel = (ir_q != IR_BYPASS);

  // Register next-state; Select-IR with TMS=1 is the only TMS path into TLR.
  always_comb begin
    ir_d     = ir_q;
    irs_d    = irs_q;
    br_d     = br_q;
    ur_d     = ur_q;
    bypass_d = bypass_q;
    if (tlr || (sel_ir && TMS)) ir_d = IR_BYPASS;
    else if (update_ir)         ir_d = ir_op_e'(irs_q);
    if (capture_ir)    irs_d = IR_CAPTURE;
    else if (shift_ir) irs_d = {TDI, irs_q[IR_W-1]};
    if (capture_dr) begin
      if (br_sel) br_d = {CoreOut, PinIn};
      else        bypass_d = 1'b0;
    end else if (shift_dr) begin
      if (br_sel) br_d = {TDI, br_q[BrW-1:1]};
      else        bypass_d = TDI;
    end
    if (update_dr && br_sel) ur_d = br_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ir_q     <= IR_BYPASS;
      irs_q    <= '0;
      br_q     <= '0;
      ur_q     <= '0;
      bypass_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      irs_q    <= irs_d;
      br_q     <= br_d;
      ur_q     <= ur_d;
      bypass_q <= bypass_d;
    end
  end

  // Serial output launched on the falling edge so it is stable at the next rise.
  always_comb begin
    tdo_en_d = shift_dr || shift_ir;
    tdo_d    = 1'b0;
    if (shift_ir)      tdo_d = irs_q[0];
    else if (shift_dr) tdo_d = br_sel ? br_q[0] : bypass_q;
  end

  always_ff @(negedge Clk or posedge Reset) begin
    if (Reset) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign TDO      = tdo_q;
  assign TDO_En   = tdo_en_q;
  assign TapState = tap_state;
  assign CoreIn   = (ir_q == IR_INTEST) ? ur_q[NIn-1:0] : PinIn;
  assign PinOut   = ((ir_q == IR_EXTEST) || (ir_q == IR_INTEST)) ? ur_q[BrW-1:NIn] : CoreOut;

endmodule

// File: tb/tb_bscan_boundary_tap.sv
// Directed and randomized scans of bscan_boundary_tap against a register-level
// model of IR/UR contents and the expected serial streams.
module tb_bscan_boundary_tap;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       TMS;
  logic       TDI;
  logic       TDO;
  logic       TDO_En;
  logic [2:0] PinIn;
  logic [2:0] CoreIn;
  logic [1:0] CoreOut;
  logic [1:0] PinOut;
  logic [3:0] TapState;

  logic       use_core;
  logic [1:0] forced_out;

  int checks = 0;
  int errors = 0;

  logic [1:0]  m_ir;
  logic [4:0]  m_ur;
  logic [63:0] got;

  bscan_boundary_tap #(.NIn(3), .NOut(2)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .TMS      (TMS),
    .TDI      (TDI),
    .TDO      (TDO),
    .TDO_En   (TDO_En),
    .PinIn    (PinIn),
    .CoreIn   (CoreIn),
    .CoreOut  (CoreOut),
    .PinOut   (PinOut),
    .TapState (TapState)
  );

  always #5 Clk = ~Clk;

  // XorNor core: X = A^B, Y = ~(C | X).
  function automatic logic [1:0] xor_nor(input logic [2:0] c);
    logic x;
    x = c[0] ^ c[1];
    return {~(c[2] | x), x};
  endfunction

  assign CoreOut = use_core ? xor_nor(CoreIn) : forced_out;

  function automatic logic [2:0] exp_core_in();
    return (m_ir == 2'b10) ? m_ur[2:0] : PinIn;
  endfunction

  function automatic logic [1:0] exp_core_out();
    return use_core ? xor_nor(exp_core_in()) : forced_out;
  endfunction

  function automatic logic [1:0] exp_pin_out();
    return (m_ir == 2'b00 || m_ir == 2'b10) ? m_ur[4:3] : exp_core_out();
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_core_in"}, 32'(CoreIn), 32'(exp_core_in()));
    check({tag, "_pin_out"}, 32'(PinOut), 32'(exp_pin_out()));
  endtask

  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge Clk);
    @(negedge Clk);
    #1;
  endtask

  // From Run-Test/Idle: load an instruction and return to Run-Test/Idle.
  task automatic ir_scan(input logic [1:0] code);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("ir_shift_state", 32'(TapState), 32'hA);
    check("ir_tdo_en", 32'(TDO_En), 32'd1);
    check("ir_tdo0", 32'(TDO), 32'd1);
    tick(1'b0, code[0]);
    check("ir_tdo1", 32'(TDO), 32'd0);
    tick(1'b1, code[1]);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    m_ir = code;
    check("ir_rti_state", 32'(TapState), 32'hC);
    check_outputs("ir_done");
  endtask

  // From Run-Test/Idle: shift n bits (LSB of vec first), optional pause after bit pause_at.
  task automatic dr_scan(input int n, input logic [63:0] vec, input int pause_at,
                         output logic [63:0] tdo_bits);
    int          w;
    logic [63:0] cap;
    logic [63:0] vm;
    logic [63:0] stream;
    w   = (m_ir == 2'b11) ? 1 : 5;
    cap = (m_ir == 2'b11) ? 64'd0 : 64'({exp_core_out(), PinIn});
    vm  = vec & ((64'd1 << n) - 64'd1);
    stream = cap | (vm << w);
    tdo_bits = '0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("dr_shift_state", 32'(TapState), 32'h2);
    for (int i = 0; i < n; i++) begin
      check("dr_tdo_en", 32'(TDO_En), 32'd1);
      check("dr_tdo", 32'(TDO), 32'(stream[i]));
      tdo_bits[i] = TDO;
      if (i == 0) check_outputs("dr_hold");
      if (i == pause_at && i != n - 1) begin
        tick(1'b1, vec[i]);
        tick(1'b0, 1'b0);
        check("pause_state", 32'(TapState), 32'h3);
        repeat (10) tick(1'b0, 1'b1);
        check("pause_tdo_en", 32'(TDO_En), 32'd0);
        check("pause_tdo", 32'(TDO), 32'd0);
        check_outputs("pause_hold");
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
      end else begin
        tick(i == n - 1, vec[i]);
      end
    end
    check_outputs("exit_hold");
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    if (m_ir != 2'b11) m_ur = 5'(stream >> n);
    check("dr_rti_state", 32'(TapState), 32'hC);
    check_outputs("dr_done");
  endtask

  initial begin
    Reset = 1'b1;
    TMS = 1'b1;
    TDI = 1'b0;
    PinIn = 3'b110;
    use_core = 1'b1;
    forced_out = 2'b00;
    m_ir = 2'b11;
    m_ur = '0;
    #12;
    check("rst_state", 32'(TapState), 32'hF);
    check("rst_tdo", 32'(TDO), 32'd0);
    check("rst_tdo_en", 32'(TDO_En), 32'd0);
    check_outputs("rst");
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("rst_release_state", 32'(TapState), 32'hF);
    tick(1'b0, 1'b0);
    check("first_rti", 32'(TapState), 32'hC);

    // Random walk, then five TMS=1 must land in Test-Logic-Reset.
    for (int r = 0; r < 3; r++) begin
      repeat (20) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat (5) tick(1'b1, 1'b0);
      check("tlr_state", 32'(TapState), 32'hF);
      check("tlr_tdo_en", 32'(TDO_En), 32'd0);
      check("tlr_core_in", 32'(CoreIn), 32'(PinIn));
      check("tlr_pin_out", 32'(PinOut), 32'(xor_nor(PinIn)));
    end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    m_ir = 2'b11;
    m_ur = '0;
    tick(1'b0, 1'b0);

    // BYPASS: 1-cycle delay of TDI.
    dr_scan(5, 64'b01101, -1, got);
    check("bypass_stream", 32'(got[4:0]), 32'b11010);

    // EXTEST load.
    ir_scan(2'b00);
    dr_scan(5, 64'b01101, -1, got);
    check("extest_pin_out", 32'(PinOut), 32'b01);
    check("extest_core_in", 32'(CoreIn), 32'(PinIn));

    // INTEST with the core attached.
    ir_scan(2'b10);
    dr_scan(5, 64'b00011, -1, got);
    check("intest_core_in", 32'(CoreIn), 32'b011);
    #20;
    dr_scan(5, 64'($urandom), -1, got);
    check("intest_xy", 32'(got[4:3]), 32'b10);

    // SAMPLE with forced core outputs.
    use_core = 1'b0;
    forced_out = 2'b10;
    PinIn = 3'b101;
    ir_scan(2'b01);
    dr_scan(5, 64'($urandom), -1, got);
    check("sample_stream", 32'(got[4:0]), 32'b10101);

    // Pause mid-shift under EXTEST.
    ir_scan(2'b00);
    dr_scan(5, 64'b10110, 2, got);
    check("pause_pin_out", 32'(PinOut), 32'b10);

    // Reset in the middle of an EXTEST shift.
    dr_scan(5, 64'b01101, -1, got);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("pre_rst_tdo_en", 32'(TDO_En), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    m_ir = 2'b11;
    m_ur = '0;
    check("mid_rst_state", 32'(TapState), 32'hF);
    check("mid_rst_tdo", 32'(TDO), 32'd0);
    check("mid_rst_tdo_en", 32'(TDO_En), 32'd0);
    check("mid_rst_pin_out", 32'(PinOut), 32'b10);
    check_outputs("mid_rst");
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    tick(1'b0, 1'b0);

    // Randomized instruction/data scans.
    for (int k = 0; k < 12; k++) begin
      int n;
      int p;
      PinIn = 3'($urandom);
      use_core = 1'($urandom_range(0, 1));
      forced_out = 2'($urandom);
      ir_scan(2'($urandom_range(0, 3)));
      n = $urandom_range(1, 12);
      p = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
      dr_scan(n, {32'($urandom), 32'($urandom)}, p, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
